// File: rtl/piso_serializer_tx.sv
// Parallel-in, serial-out transmitter with valid/ready intake and registered
// serial outputs (sdo, frame qualifier, sample strobe, end-of-word pulse).
module piso_serializer_tx #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             valid,
  output logic             ready,
  output logic             sdo,
  output logic             sframe,
  output logic             sstrobe,
  output logic             done
);

  localparam int BCW = $clog2(WIDTH);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [BCW-1:0] BIT_LAST   = BCW'(WIDTH - 1);
  localparam logic [DCW-1:0] DIV_LAST   = DCW'(DIV - 1);
  localparam logic           STROBE_NOW = (DIV == 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;
  logic             sdo_q, sdo_d;
  logic             sframe_q, sframe_d;
  logic             sstrobe_q, sstrobe_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_rot;

  // The register rotates rather than shifts so every stored bit stays live;
  // the bit heading for sdo always sits at the output end.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign first_bit = din[WIDTH-1];
      assign shreg_rot = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
      assign next_bit  = shreg_rot[WIDTH-1];
    end else begin : g_lsb_first
      assign first_bit = din[0];
      assign shreg_rot = {shreg_q[0], shreg_q[WIDTH-1:1]};
      assign next_bit  = shreg_rot[0];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sdo_d     = sdo_q;
    sframe_d  = sframe_q;
    sstrobe_d = 1'b0;
    done_d    = 1'b0;
    ready_d   = ready_q;

    case (state_q)
      IDLE: begin
        if (valid && ready_q) begin
          shreg_d   = din;
          sdo_d     = first_bit;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          ready_d   = 1'b0;
          sframe_d  = 1'b1;
          sstrobe_d = STROBE_NOW;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        // sstrobe is registered, so it is computed from the divide count the
        // next cycle will hold.
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d  = IDLE;
            sframe_d = 1'b0;
            sdo_d    = 1'b0;
            done_d   = 1'b1;
            ready_d  = 1'b1;
          end else begin
            shreg_d   = shreg_rot;
            sdo_d     = next_bit;
            bit_cnt_d = bit_cnt_q + BCW'(1);
            sstrobe_d = STROBE_NOW;
          end
        end else begin
          div_cnt_d = div_cnt_q + DCW'(1);
          sstrobe_d = ((div_cnt_q + DCW'(1)) == DIV_LAST);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sdo_q     <= 1'b0;
      sframe_q  <= 1'b0;
      sstrobe_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sdo_q     <= sdo_d;
      sframe_q  <= sframe_d;
      sstrobe_q <= sstrobe_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign ready   = ready_q;
  assign sdo     = sdo_q;
  assign sframe  = sframe_q;
  assign sstrobe = sstrobe_q;
  assign done    = done_q;

endmodule
